control_sequencer: RTL and testbench

- Microcoded control unit for the SAP-1.5 8-bit computer.
- Runs the fetch/decode/execute step sequence and drives every bus-enable and load strobe in the datapath: PC, MAR, RAM, IR, register A, register B, ALU, flags and output register.
- Sits directly upstream of register A, register B and the ALU/flag stage.
- Fixes instruction timing: fetch 5 cycles, LDA +4, ADD/SUB +6.

---
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the SAP-1.5 sequencer and its datapath: the opcode and
// flags flowing in, and every bus-enable / load strobe flowing out.
//
// Handshake: there is no valid/ready pairing on this bus. Each strobe is a
// level that is meaningful for exactly one clock cycle, and the addressed
// register latches at the rising edge that ends that cycle. opcode_i is
// valid from fetch step F4 onward. The flags are latched values owned by
// the datapath.
interface control_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic [OPCODE_WIDTH-1:0] opcode_i;
    logic                    flag_zero_i;
    logic                    flag_carry_i;
    logic                    pc_inc_o;
    logic                    pc_load_o;
    logic                    pc_oe_o;
    logic                    mar_load_o;
    logic                    ram_oe_o;
    logic                    ram_we_o;
    logic                    ir_load_o;
    logic                    ir_oe_o;
    logic                    a_load_o;
    logic                    a_oe_o;
    logic                    b_load_o;
    logic                    alu_oe_o;
    logic                    alu_sub_o;
    logic                    flags_load_o;
    logic                    out_load_o;
    logic                    halt_o;
    logic                    instr_done_o;

    // Sequencer side: consumes opcode/flags, produces strobes.
    modport master (
        input  opcode_i, flag_zero_i, flag_carry_i,
        output pc_inc_o, pc_load_o, pc_oe_o, mar_load_o, ram_oe_o, ram_we_o,
               ir_load_o, ir_oe_o, a_load_o, a_oe_o, b_load_o, alu_oe_o,
               alu_sub_o, flags_load_o, out_load_o, halt_o, instr_done_o
    );

    // Datapath side: produces opcode/flags, consumes strobes.
    modport slave (
        output opcode_i, flag_zero_i, flag_carry_i,
        input  pc_inc_o, pc_load_o, pc_oe_o, mar_load_o, ram_oe_o, ram_we_o,
               ir_load_o, ir_oe_o, a_load_o, a_oe_o, b_load_o, alu_oe_o,
               alu_sub_o, flags_load_o, out_load_o, halt_o, instr_done_o
    );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1.5 microcoded control unit. A phase register (fetch / execute / halt)
// plus a microstep counter walks the instruction; every strobe is a Moore
// decode of that state and the opcode, and is forced low while reset is high.
// dbg_state_o exposes {phase, step} so checkers can follow the sequence.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   ctrl,
    output logic [STEP_WIDTH+1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_HALT  = 2'd2
    } phase_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 'hF;

    localparam logic [STEP_WIDTH-1:0] S0 = 'd0;
    localparam logic [STEP_WIDTH-1:0] S2 = 'd2;
    localparam logic [STEP_WIDTH-1:0] S3 = 'd3;
    localparam logic [STEP_WIDTH-1:0] S4 = 'd4;
    localparam logic [STEP_WIDTH-1:0] S5 = 'd5;
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = 'd1;

    phase_t                phase_q;
    logic [STEP_WIDTH-1:0] step_q;
    logic                  halt_entry_q;
    logic [STEP_WIDTH-1:0] exec_last;

    // Index of the final execute step for the current opcode.
    always_comb begin
        exec_last = S0;
        case (ctrl.opcode_i)
            OP_LDA:         exec_last = S3;
            OP_ADD, OP_SUB: exec_last = S5;
            OP_STA:         exec_last = S2;
            default:        exec_last = S0;
        endcase
    end

    // Sequencing: fetch F0..F4, then execute E0..last, or halt after F4 on HLT.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= PH_FETCH;
            step_q       <= S0;
            halt_entry_q <= 1'b0;
        end else begin
            halt_entry_q <= 1'b0;
            case (phase_q)
                PH_FETCH: begin
                    if (step_q == S4) begin
                        step_q <= S0;
                        if (ctrl.opcode_i == OP_HLT) begin
                            phase_q      <= PH_HALT;
                            halt_entry_q <= 1'b1;
                        end else begin
                            phase_q <= PH_EXEC;
                        end
                    end else if (step_q > S4) begin
                        step_q <= S0;
                    end else begin
                        step_q <= step_q + STEP_ONE;
                    end
                end
                PH_EXEC: begin
                    // The >= also catches an opcode that shortened mid-instruction.
                    if (step_q >= exec_last || step_q >= S5) begin
                        phase_q <= PH_FETCH;
                        step_q  <= S0;
                    end else begin
                        step_q <= step_q + STEP_ONE;
                    end
                end
                PH_HALT: begin
                    step_q <= S0;
                end
                default: begin
                    phase_q <= PH_FETCH;
                    step_q  <= S0;
                end
            endcase
        end
    end

    // Strobe decode from phase, step and opcode; all low during reset.
    always_comb begin
        ctrl.pc_inc_o     = 1'b0;
        ctrl.pc_load_o    = 1'b0;
        ctrl.pc_oe_o      = 1'b0;
        ctrl.mar_load_o   = 1'b0;
        ctrl.ram_oe_o     = 1'b0;
        ctrl.ram_we_o     = 1'b0;
        ctrl.ir_load_o    = 1'b0;
        ctrl.ir_oe_o      = 1'b0;
        ctrl.a_load_o     = 1'b0;
        ctrl.a_oe_o       = 1'b0;
        ctrl.b_load_o     = 1'b0;
        ctrl.alu_oe_o     = 1'b0;
        ctrl.alu_sub_o    = 1'b0;
        ctrl.flags_load_o = 1'b0;
        ctrl.out_load_o   = 1'b0;
        ctrl.halt_o       = 1'b0;
        ctrl.instr_done_o = 1'b0;
        if (!reset) begin
            case (phase_q)
                PH_FETCH: begin
                    if (step_q == S0) begin
                        ctrl.pc_oe_o    = 1'b1;
                        ctrl.mar_load_o = 1'b1;
                    end else if (step_q == S2) begin
                        ctrl.ram_oe_o  = 1'b1;
                        ctrl.ir_load_o = 1'b1;
                    end else if (step_q == S3) begin
                        ctrl.pc_inc_o = 1'b1;
                    end
                end
                PH_EXEC: begin
                    case (ctrl.opcode_i)
                        OP_LDA: begin
                            if (step_q == S0) begin
                                ctrl.ir_oe_o    = 1'b1;
                                ctrl.mar_load_o = 1'b1;
                            end else if (step_q == S3) begin
                                ctrl.ram_oe_o     = 1'b1;
                                ctrl.a_load_o     = 1'b1;
                                ctrl.instr_done_o = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (step_q == S0) begin
                                ctrl.ir_oe_o    = 1'b1;
                                ctrl.mar_load_o = 1'b1;
                            end else if (step_q == S2) begin
                                ctrl.ram_oe_o = 1'b1;
                                ctrl.b_load_o = 1'b1;
                            end else if (step_q == S4) begin
                                ctrl.alu_oe_o     = 1'b1;
                                ctrl.a_load_o     = 1'b1;
                                ctrl.flags_load_o = 1'b1;
                                ctrl.alu_sub_o    = (ctrl.opcode_i == OP_SUB);
                            end else if (step_q == S5) begin
                                ctrl.instr_done_o = 1'b1;
                            end
                        end
                        OP_STA: begin
                            if (step_q == S0) begin
                                ctrl.ir_oe_o    = 1'b1;
                                ctrl.mar_load_o = 1'b1;
                            end else if (step_q == S2) begin
                                ctrl.a_oe_o       = 1'b1;
                                ctrl.ram_we_o     = 1'b1;
                                ctrl.instr_done_o = 1'b1;
                            end
                        end
                        OP_LDI: begin
                            ctrl.ir_oe_o      = 1'b1;
                            ctrl.a_load_o     = 1'b1;
                            ctrl.instr_done_o = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl.ir_oe_o      = 1'b1;
                            ctrl.pc_load_o    = 1'b1;
                            ctrl.instr_done_o = 1'b1;
                        end
                        OP_JC: begin
                            ctrl.ir_oe_o      = ctrl.flag_carry_i;
                            ctrl.pc_load_o    = ctrl.flag_carry_i;
                            ctrl.instr_done_o = 1'b1;
                        end
                        OP_JZ: begin
                            ctrl.ir_oe_o      = ctrl.flag_zero_i;
                            ctrl.pc_load_o    = ctrl.flag_zero_i;
                            ctrl.instr_done_o = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.a_oe_o       = 1'b1;
                            ctrl.out_load_o   = 1'b1;
                            ctrl.instr_done_o = 1'b1;
                        end
                        default: begin
                            // NOP and undefined opcodes: a single done-only step.
                            ctrl.instr_done_o = 1'b1;
                        end
                    endcase
                end
                PH_HALT: begin
                    ctrl.halt_o       = 1'b1;
                    ctrl.instr_done_o = halt_entry_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state_o = {phase_q, step_q};
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. A table model expands each instruction into
// its expected per-cycle strobe vector; vectors are compared at the falling
// edge, together with a check that no more than one bus driver is active.
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] dbg_state;

    control_sequencer_if bus ();

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (bus),
        .dbg_state_o (dbg_state)
    );

    // Strobe vector layout.
    localparam logic [16:0] M_PC_INC   = 17'h10000;
    localparam logic [16:0] M_PC_LOAD  = 17'h08000;
    localparam logic [16:0] M_PC_OE    = 17'h04000;
    localparam logic [16:0] M_MAR_LOAD = 17'h02000;
    localparam logic [16:0] M_RAM_OE   = 17'h01000;
    localparam logic [16:0] M_RAM_WE   = 17'h00800;
    localparam logic [16:0] M_IR_LOAD  = 17'h00400;
    localparam logic [16:0] M_IR_OE    = 17'h00200;
    localparam logic [16:0] M_A_LOAD   = 17'h00100;
    localparam logic [16:0] M_A_OE     = 17'h00080;
    localparam logic [16:0] M_B_LOAD   = 17'h00040;
    localparam logic [16:0] M_ALU_OE   = 17'h00020;
    localparam logic [16:0] M_ALU_SUB  = 17'h00010;
    localparam logic [16:0] M_FLAGS    = 17'h00008;
    localparam logic [16:0] M_OUT_LOAD = 17'h00004;
    localparam logic [16:0] M_DONE     = 17'h00002;
    localparam logic [16:0] M_HALT     = 17'h00001;

    logic [16:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [16:0] observed();
        return {bus.pc_inc_o, bus.pc_load_o, bus.pc_oe_o, bus.mar_load_o,
                bus.ram_oe_o, bus.ram_we_o, bus.ir_load_o, bus.ir_oe_o,
                bus.a_load_o, bus.a_oe_o, bus.b_load_o, bus.alu_oe_o,
                bus.alu_sub_o, bus.flags_load_o, bus.out_load_o,
                bus.instr_done_o, bus.halt_o};
    endfunction

    // Reference model: the per-cycle strobe sequence of one instruction.
    task automatic push_instr(input logic [3:0] op, input logic z, input logic c);
        exp_q.push_back(M_PC_OE | M_MAR_LOAD);
        exp_q.push_back(17'h0);
        exp_q.push_back(M_RAM_OE | M_IR_LOAD);
        exp_q.push_back(M_PC_INC);
        exp_q.push_back(17'h0);
        case (op)
            4'h1: begin
                exp_q.push_back(M_IR_OE | M_MAR_LOAD);
                exp_q.push_back(17'h0);
                exp_q.push_back(17'h0);
                exp_q.push_back(M_RAM_OE | M_A_LOAD | M_DONE);
            end
            4'h2, 4'h3: begin
                exp_q.push_back(M_IR_OE | M_MAR_LOAD);
                exp_q.push_back(17'h0);
                exp_q.push_back(M_RAM_OE | M_B_LOAD);
                exp_q.push_back(17'h0);
                exp_q.push_back(M_ALU_OE | M_A_LOAD | M_FLAGS | ((op == 4'h3) ? M_ALU_SUB : 17'h0));
                exp_q.push_back(M_DONE);
            end
            4'h4: begin
                exp_q.push_back(M_IR_OE | M_MAR_LOAD);
                exp_q.push_back(17'h0);
                exp_q.push_back(M_A_OE | M_RAM_WE | M_DONE);
            end
            4'h5: exp_q.push_back(M_IR_OE | M_A_LOAD | M_DONE);
            4'h6: exp_q.push_back(M_IR_OE | M_PC_LOAD | M_DONE);
            4'h7: exp_q.push_back(M_DONE | (c ? (M_IR_OE | M_PC_LOAD) : 17'h0));
            4'h8: exp_q.push_back(M_DONE | (z ? (M_IR_OE | M_PC_LOAD) : 17'h0));
            4'hE: exp_q.push_back(M_A_OE | M_OUT_LOAD | M_DONE);
            4'hF: exp_q.push_back(M_HALT | M_DONE);
            default: exp_q.push_back(M_DONE);
        endcase
    endtask

    // Consume the expected queue one cycle at a time.
    task automatic drain(input string name);
        logic [16:0] exp_v;
        logic [16:0] got;
        int drivers;
        int cyc;
        cyc = 1;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: strobes got %05h expected %05h", name, cyc, got, exp_v);
            end
            drivers = int'(bus.pc_oe_o) + int'(bus.ram_oe_o) + int'(bus.ir_oe_o)
                    + int'(bus.a_oe_o) + int'(bus.alu_oe_o);
            checks++;
            if (drivers > 1) begin
                errors++;
                $display("FAIL %s cycle %0d: bus drivers got %0d expected <=1", name, cyc, drivers);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input logic z, input logic c);
        bus.opcode_i     = op;
        bus.flag_zero_i  = z;
        bus.flag_carry_i = c;
        push_instr(op, z, c);
        drain(name);
    endtask

    // Hold reset for n cycles checking that every output stays low.
    task automatic hold_reset(input string name, input int n);
        logic [16:0] got;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.opcode_i     = 4'($urandom_range(0, 15));
            bus.flag_zero_i  = 1'($urandom_range(0, 1));
            bus.flag_carry_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== 17'h0) begin
                errors++;
                $display("FAIL %s reset cycle %0d: strobes got %05h expected 00000", name, i, got);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        hold_reset("reset", 3);
    endtask

    task automatic test_lda_add();
        run_instr("lda", 4'h1, 1'b0, 1'b0);
        run_instr("add", 4'h2, 1'b0, 1'b0);
        run_instr("sub", 4'h3, 1'b1, 1'b1);
    endtask

    task automatic test_jumps();
        run_instr("jz_taken", 4'h8, 1'b1, 1'b0);
        run_instr("jz_not_taken", 4'h8, 1'b0, 1'b1);
        run_instr("jc_taken", 4'h7, 1'b0, 1'b1);
        run_instr("jc_not_taken", 4'h7, 1'b1, 1'b0);
        run_instr("jmp", 4'h6, 1'b0, 1'b0);
    endtask

    task automatic test_misc_ops();
        run_instr("sta", 4'h4, 1'b0, 1'b0);
        run_instr("ldi", 4'h5, 1'b0, 1'b0);
        run_instr("out", 4'hE, 1'b0, 1'b0);
        run_instr("nop", 4'h0, 1'b0, 1'b0);
        run_instr("undef_a", 4'hA, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr("random", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_halt();
        bus.opcode_i = 4'hF;
        push_instr(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 49; i++) exp_q.push_back(M_HALT);
        drain("halt");
        hold_reset("halt_reset", 1);
        run_instr("after_halt", 4'h5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_add();
        bus.opcode_i = 4'h2;
        push_instr(4'h2, 1'b0, 1'b0);
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        drain("add_abort");
        hold_reset("add_abort", 2);
        run_instr("after_abort", 4'h1, 1'b0, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.opcode_i     = 4'h0;
        bus.flag_zero_i  = 1'b0;
        bus.flag_carry_i = 1'b0;
        test_reset();
        test_lda_add();
        test_jumps();
        test_misc_ops();
        test_back_to_back();
        test_reset_mid_add();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
